mm_result_writer: RTL and testbench

MM_RESULT_WRITER -- requirements
Module: mm_result_writer

---
 rtl/mm_result_writer_pkg.sv | 57 +++++
 rtl/mm_result_writer_if.sv | 23 ++
 rtl/mm_wr_skid.sv | 53 +++++
 rtl/mm_result_writer.sv | 137 +++++++++++++
 tb/tb_mm_result_writer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mm_result_writer_pkg.sv
// Shared parameters for the Montgomery-multiplier result writer: top-FSM state codes,
// defaults, destination-mask bit positions and the state-to-mask decode.
package mm_result_writer_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned NUM_WORDS_DEF  = 16;
    localparam int unsigned SKID_DEPTH_DEF = 4;

    // Top-FSM state codes; 3'd6 and 3'd7 are unused
    localparam logic [2:0] ENTER1 = 3'd0;
    localparam logic [2:0] ENTER2 = 3'd1;
    localparam logic [2:0] SS_MM  = 3'd2;
    localparam logic [2:0] CS_MM  = 3'd3;
    localparam logic [2:0] CS_PR  = 3'd4;
    localparam logic [2:0] EXIT   = 3'd5;

    localparam int unsigned MASK_SS0   = 0;
    localparam int unsigned MASK_SS1   = 1;
    localparam int unsigned MASK_SS2   = 2;
    localparam int unsigned MASK_CS    = 3;
    localparam int unsigned MASK_CS_PR = 4;
    localparam int unsigned MASK_SS_PR = 5;
    localparam int unsigned MASK_OUT   = 6;
    localparam int unsigned NUM_DEST   = 7;

    typedef logic [NUM_DEST-1:0] dest_mask_t;

    typedef enum logic [1:0] {WrIdle, WrCollect, WrDrain} wr_state_e;

    function automatic dest_mask_t dest_mask(input logic [2:0] code);
        dest_mask_t m;
        m = '0;
        case (code)
            ENTER1: begin
                m[MASK_SS0] = 1'b1;
                m[MASK_SS1] = 1'b1;
                m[MASK_SS2] = 1'b1;
            end
            ENTER2: m[MASK_CS] = 1'b1;
            SS_MM: begin
                m[MASK_SS0]   = 1'b1;
                m[MASK_SS1]   = 1'b1;
                m[MASK_SS2]   = 1'b1;
                m[MASK_SS_PR] = 1'b1;
            end
            CS_MM: begin
                m[MASK_CS]    = 1'b1;
                m[MASK_CS_PR] = 1'b1;
            end
            CS_PR:   m[MASK_CS]  = 1'b1;
            EXIT:    m[MASK_OUT] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mm_result_writer_if.sv
// Destination-FIFO write bus of the result writer: per-FIFO full flags in, write
// strobes and the shared write word out.
interface mm_result_writer_if;
    import mm_result_writer_pkg::*;

    logic              SS0_full, SS1_full, SS2_full, CS_full, CS_PR_full, SS_PR_full, OUT_full;
    logic              WR_SS0_EN, WR_SS1_EN, WR_SS2_EN, WR_CS_EN, WR_CS_PR_EN, WR_SS_PR_EN;
    logic              WR_OUT_EN;
    logic [WORD_W-1:0] wr_data;

    modport master (
        input  SS0_full, SS1_full, SS2_full, CS_full, CS_PR_full, SS_PR_full, OUT_full,
        output WR_SS0_EN, WR_SS1_EN, WR_SS2_EN, WR_CS_EN, WR_CS_PR_EN, WR_SS_PR_EN, WR_OUT_EN,
        output wr_data
    );

    modport slave (
        output SS0_full, SS1_full, SS2_full, CS_full, CS_PR_full, SS_PR_full, OUT_full,
        input  WR_SS0_EN, WR_SS1_EN, WR_SS2_EN, WR_CS_EN, WR_CS_PR_EN, WR_SS_PR_EN, WR_OUT_EN,
        input  wr_data
    );

endinterface

// File: rtl/mm_wr_skid.sv
// Result holding buffer: synchronous FIFO with flush; a push into a full buffer without a
// concurrent pop is dropped. DEPTH must be a power of two so the pointers wrap naturally.
module mm_wr_skid #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mm_result_writer.sv
// Routes Montgomery-multiplier result words to the destination FIFOs selected by the top
// FSM state. Define MM_WR_OVF_CHK_EN to enable the sticky skid-overflow flag.
module mm_result_writer
    import mm_result_writer_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = NUM_WORDS_DEF,
    parameter int unsigned SKID_DEPTH = SKID_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [2:0]                state,
    input  logic                      mm_start,
    input  logic                      res_valid,
    input  logic [WORD_W-1:0]         res_data,
    mm_result_writer_if.master        wr_bus,
    output logic                      busy,
    output logic                      mm_done,
    output logic                      ovf
);

    localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);

    wr_state_e         st_q, st_d;
    dest_mask_t        mask_q, full_vec, wr_en_q;
    logic [CNT_W-1:0]  acc_cnt_q, wr_cnt_q;
    logic [WORD_W-1:0] wr_data_q, wdata, skid_pop_data;
    logic              mm_done_q, done_now;
    logic              accept, mask_full, can_wr, bypass, write;
    logic              skid_push, skid_pop, skid_full, skid_empty;

    always_comb begin
        full_vec             = '0;
        full_vec[MASK_SS0]   = wr_bus.SS0_full;
        full_vec[MASK_SS1]   = wr_bus.SS1_full;
        full_vec[MASK_SS2]   = wr_bus.SS2_full;
        full_vec[MASK_CS]    = wr_bus.CS_full;
        full_vec[MASK_CS_PR] = wr_bus.CS_PR_full;
        full_vec[MASK_SS_PR] = wr_bus.SS_PR_full;
        full_vec[MASK_OUT]   = wr_bus.OUT_full;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st_q <= WrIdle;
        else       st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            WrIdle:    if (mm_start) st_d = WrCollect;
            WrCollect: begin
                if (mm_start) st_d = WrCollect;
                else if (accept && acc_cnt_q == CNT_W'(NUM_WORDS - 1)) st_d = WrDrain;
            end
            WrDrain: begin
                if (mm_start) st_d = WrCollect;
                else if (wr_cnt_q == CNT_W'(NUM_WORDS)) st_d = WrIdle;
            end
            default: st_d = WrIdle;
        endcase
    end

    // An incoming word bypasses an empty skid straight into the output register
    always_comb begin
        busy      = (st_q != WrIdle);
        accept    = (st_q == WrCollect) && res_valid && !mm_start;
        mask_full = |(mask_q & full_vec);
        can_wr    = busy && !mm_start && !mask_full;
        bypass    = can_wr && skid_empty && accept;
        skid_pop  = can_wr && !skid_empty;
        write     = skid_pop || bypass;
        wdata     = skid_empty ? res_data : skid_pop_data;
        skid_push = accept && !bypass && (!skid_full || skid_pop);
        done_now  = !mm_start && (st_q == WrDrain) && (wr_cnt_q == CNT_W'(NUM_WORDS));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask_q    <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            mm_done_q <= 1'b0;
        end else begin
            wr_en_q   <= write ? mask_q : '0;
            wr_data_q <= (write && |mask_q) ? wdata : '0;
            mm_done_q <= done_now;
            if (mm_start) begin
                mask_q    <= dest_mask(state);
                acc_cnt_q <= '0;
                wr_cnt_q  <= '0;
            end else begin
                if (accept) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
                if (write)  wr_cnt_q  <= wr_cnt_q + CNT_W'(1);
            end
        end
    end

    mm_wr_skid #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (WORD_W)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (mm_start),
        .push      (skid_push),
        .push_data (res_data),
        .pop       (skid_pop),
        .pop_data  (skid_pop_data),
        .full      (skid_full),
        .empty     (skid_empty)
    );

`ifdef MM_WR_OVF_CHK_EN
    logic ovf_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                      ovf_q <= 1'b0;
        else if (mm_start)                              ovf_q <= 1'b0;
        else if (accept && !bypass && skid_full && !skid_pop) ovf_q <= 1'b1;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign mm_done            = mm_done_q;
    assign wr_bus.wr_data     = wr_data_q;
    assign wr_bus.WR_SS0_EN   = wr_en_q[MASK_SS0];
    assign wr_bus.WR_SS1_EN   = wr_en_q[MASK_SS1];
    assign wr_bus.WR_SS2_EN   = wr_en_q[MASK_SS2];
    assign wr_bus.WR_CS_EN    = wr_en_q[MASK_CS];
    assign wr_bus.WR_CS_PR_EN = wr_en_q[MASK_CS_PR];
    assign wr_bus.WR_SS_PR_EN = wr_en_q[MASK_SS_PR];
    assign wr_bus.WR_OUT_EN   = wr_en_q[MASK_OUT];

endmodule

// File: tb/tb_mm_result_writer.sv
// Directed bench for mm_result_writer: a depth-4 instance for most checks and a depth-8
// instance for the long full-stall case; both see identical stimulus.
module tb_mm_result_writer;
    import mm_result_writer_pkg::*;

`ifdef MM_WR_OVF_CHK_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  state = '0;
    logic        mm_start = 1'b0;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = '0;
    logic [6:0]  full_v = '0;
    logic        busy4, done4, ovf4, busy8, done8, ovf8;
    logic [6:0]  wr4, wr8;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mm_result_writer_if bus4 ();
    mm_result_writer_if bus8 ();

    assign bus4.SS0_full   = full_v[0];
    assign bus4.SS1_full   = full_v[1];
    assign bus4.SS2_full   = full_v[2];
    assign bus4.CS_full    = full_v[3];
    assign bus4.CS_PR_full = full_v[4];
    assign bus4.SS_PR_full = full_v[5];
    assign bus4.OUT_full   = full_v[6];
    assign bus8.SS0_full   = full_v[0];
    assign bus8.SS1_full   = full_v[1];
    assign bus8.SS2_full   = full_v[2];
    assign bus8.CS_full    = full_v[3];
    assign bus8.CS_PR_full = full_v[4];
    assign bus8.SS_PR_full = full_v[5];
    assign bus8.OUT_full   = full_v[6];

    assign wr4 = {bus4.WR_OUT_EN, bus4.WR_SS_PR_EN, bus4.WR_CS_PR_EN, bus4.WR_CS_EN,
                  bus4.WR_SS2_EN, bus4.WR_SS1_EN, bus4.WR_SS0_EN};
    assign wr8 = {bus8.WR_OUT_EN, bus8.WR_SS_PR_EN, bus8.WR_CS_PR_EN, bus8.WR_CS_EN,
                  bus8.WR_SS2_EN, bus8.WR_SS1_EN, bus8.WR_SS0_EN};

    mm_result_writer #(.NUM_WORDS(16), .SKID_DEPTH(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .state     (state),
        .mm_start  (mm_start),
        .res_valid (res_valid),
        .res_data  (res_data),
        .wr_bus    (bus4),
        .busy      (busy4),
        .mm_done   (done4),
        .ovf       (ovf4)
    );

    mm_result_writer #(.NUM_WORDS(16), .SKID_DEPTH(8)) dut_d8 (
        .clk       (clk),
        .rstn      (rstn),
        .state     (state),
        .mm_start  (mm_start),
        .res_valid (res_valid),
        .res_data  (res_data),
        .wr_bus    (bus8),
        .busy      (busy8),
        .mm_done   (done8),
        .ovf       (ovf8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        mm_start  = 1'b0;
        res_valid = 1'b0;
        full_v    = '0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic start_op(input logic [2:0] code);
        state     = code;
        mm_start  = 1'b1;
        res_valid = 1'b0;
        step();
        mm_start = 1'b0;
    endtask

    initial begin
        int ew;
        step();
        check("rst_outs", {busy4, done4, ovf4, wr4, bus4.wr_data}, 64'd0);
        do_reset();

        // SS_MM, back-to-back words, no FIFO full
        start_op(SS_MM);
        check("ss_busy0", busy4, 1);
        for (int c = 1; c <= 18; c++) begin
            res_valid = (c <= 16);
            res_data  = 32'(c);
            step();
            check("ss_wr", {wr4, bus4.wr_data}, (c <= 16) ? {7'h27, 32'(c)} : 39'd0);
            check("ss_done", done4, (c == 17) ? 1 : 0);
            check("ss_busy", busy4, (c <= 16) ? 1 : 0);
        end

        // CS_MM with CS_full while words 3..8 arrive (depth-8 instance)
        do_reset();
        start_op(CS_MM);
        for (int c = 1; c <= 24; c++) begin
            res_valid = (c <= 16);
            res_data  = 32'(c);
            full_v    = (c >= 3 && c <= 8) ? 7'h08 : 7'h00;
            step();
            ew = (c <= 2) ? c : (c >= 9 && c <= 22) ? c - 6 : 0;
            check("cs_wr", {wr8, bus8.wr_data}, (ew != 0) ? {7'h18, 32'(ew)} : 39'd0);
            check("cs_done", done8, (c == 23) ? 1 : 0);
        end

        // Abort after 7 words with 3 still buffered; restart with ENTER2
        do_reset();
        start_op(ENTER1);
        for (int c = 1; c <= 7; c++) begin
            res_valid = 1'b1;
            res_data  = 32'(c);
            full_v    = (c >= 5) ? 7'h02 : 7'h00;
            step();
            check("ab_wr", {wr4, bus4.wr_data}, (c <= 4) ? {7'h07, 32'(c)} : 39'd0);
            check("ab_done", done4, 0);
        end
        start_op(ENTER2);
        check("ab_flush", {wr4, bus4.wr_data}, 64'd0);
        for (int c = 9; c <= 25; c++) begin
            res_valid = (c <= 24);
            res_data  = 32'h100 + 32'(c - 8);
            step();
            check("ab_wr2", {wr4, bus4.wr_data},
                  (c <= 24) ? {7'h08, 32'h100 + 32'(c - 8)} : 39'd0);
            check("ab_done2", done4, (c == 25) ? 1 : 0);
        end
        full_v = '0;

        // Reset asserted mid-DRAIN with words 13..16 still buffered
        do_reset();
        start_op(CS_PR);
        for (int c = 1; c <= 18; c++) begin
            res_valid = (c <= 16);
            res_data  = 32'(c);
            full_v    = (c >= 13) ? 7'h08 : 7'h00;
            step();
            check("dr_wr", {wr4, bus4.wr_data}, (c <= 12) ? {7'h08, 32'(c)} : 39'd0);
        end
        res_valid = 1'b0;
        check("dr_busy", busy4, 1);
        rstn = 1'b0;
        #1;
        check("dr_rst", {busy4, done4, ovf4, wr4, bus4.wr_data}, 64'd0);
        full_v = '0;
        step();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("dr_quiet", {busy4, done4, wr4, bus4.wr_data}, 64'd0);
        end

        // Undefined state code: words consumed, nothing strobed
        do_reset();
        start_op(3'b111);
        for (int c = 1; c <= 17; c++) begin
            res_valid = (c <= 16);
            res_data  = 32'hA0 + 32'(c);
            step();
            check("ud_wr", {wr4, bus4.wr_data}, 64'd0);
            check("ud_done", done4, (c == 17) ? 1 : 0);
            check("ud_busy", busy4, (c <= 16) ? 1 : 0);
        end

        // EXIT with OUT_full held: fifth word overflows the depth-4 skid
        do_reset();
        full_v = 7'h40;
        start_op(EXIT);
        for (int c = 1; c <= 6; c++) begin
            res_valid = 1'b1;
            res_data  = 32'(c);
            step();
            check("ov_wr", {wr4, bus4.wr_data}, 64'd0);
            check("ov_flag", ovf4, (c >= 5) ? {63'd0, OVF_EN} : 64'd0);
        end
        start_op(EXIT);
        check("ov_clr", ovf4, 0);
        res_valid = 1'b0;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
